// File: rtl/rr_stream_mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer.
package rr_stream_mux_pkg;

    // Grant-source selection for the MODE parameter.
    localparam int MUX_MODE_SEL = 0;  // channel chosen by the external select input
    localparam int MUX_MODE_RR  = 1;  // channel chosen by round-robin arbitration

    // Widest supported channel count and the index width it needs.
    localparam int MAX_IN    = 16;
    localparam int MAX_IDX_W = 4;

    // Encode a one-hot (or all-zero) vector into a binary index.
    // An all-zero input encodes to 0; callers qualify with |grant.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_IN-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_IN; i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_stream_mux_if.sv
// Stream bundle for the N:1 multiplexer: N producer channels in, one consumer out.
// master = producers/consumer side, slave = the multiplexer.
interface rr_stream_mux_if #(
    parameter int NUM_IN   = 4,
    parameter int BIT_SIZE = 18
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*BIT_SIZE-1:0] in_data;    // channel i at [i*BIT_SIZE +: BIT_SIZE]
    logic [NUM_IN-1:0]          in_valid;
    logic [NUM_IN-1:0]          in_ready;   // at most one bit set
    logic [BIT_SIZE-1:0]        out_data;
    logic [SEL_W-1:0]           out_sel;    // channel that produced out_data
    logic                       out_valid;
    logic                       out_ready;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

endinterface

// File: rtl/rr_stream_mux_rr_grant.sv
// Round-robin grant: first requesting channel at or after ptr, wrapping modulo NUM_IN.
// The request vector is doubled so a plain right shift acts as a rotate; the lowest
// set bit of the rotated vector is isolated, then rotated back by the same amount.
module rr_grant #(
    parameter int NUM_IN = 4,
    localparam int SEL_W = $clog2(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,    // always < NUM_IN
    output logic [NUM_IN-1:0] grant_o
);

    logic [NUM_IN-1:0] req_rot;
    logic [NUM_IN-1:0] pri_rot;

    // Rotate requests so ptr lands on bit 0, pick the lowest one, rotate back.
    always_comb begin
        req_rot = NUM_IN'({req_i, req_i} >> ptr_i);
        pri_rot = req_rot & (~req_rot + NUM_IN'(1));
        grant_o = NUM_IN'(({pri_rot, pri_rot} << ptr_i) >> NUM_IN);
    end

endmodule

// File: rtl/rr_stream_mux.sv
// N:1 stream multiplexer with a registered output stage.
// MODE selects the grant source (external select or round-robin); the chosen word is
// captured in one register stage, giving 1-cycle latency at full throughput.
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter int  BIT_SIZE = 18,
    parameter int  NUM_IN   = 4,
    parameter int  MODE     = MUX_MODE_SEL,
    localparam int SEL_W    = $clog2(NUM_IN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,   // synchronous clear of the output stage
    input  logic [SEL_W-1:0]  sel_i,     // used only when MODE selects external control
    rr_stream_mux_if.slave    bus
);

    logic                load;
    logic                xfer_en;
    logic [NUM_IN-1:0]   grant_sel;
    logic [NUM_IN-1:0]   grant_rr;
    logic [NUM_IN-1:0]   grant;
    logic [SEL_W-1:0]    grant_idx;
    logic [BIT_SIZE-1:0] mux_data;

    logic                out_valid_q, out_valid_d;
    logic [BIT_SIZE-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]    out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]    rr_ptr_q,    rr_ptr_d;

    // The output register can take a new word when empty or being drained this cycle.
    assign load    = ~out_valid_q | bus.out_ready;
    assign xfer_en = load & ~flush_i;

    // External-select grant; an out-of-range select (non-power-of-2 NUM_IN) grants nothing.
    always_comb begin
        grant_sel = '0;
        if (int'(sel_i) < NUM_IN) grant_sel[sel_i] = bus.in_valid[sel_i];
    end

    rr_grant #(.NUM_IN(NUM_IN)) u_rr_grant (
        .req_i   (bus.in_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_rr)
    );

    assign grant     = (MODE == MUX_MODE_RR) ? grant_rr : grant_sel;
    assign grant_idx = SEL_W'(onehot_to_idx(MAX_IN'(grant)));

    // Ready is the grant qualified by load/flush, and held low throughout reset.
    assign bus.in_ready = rst ? '0 : (grant & {NUM_IN{xfer_en}});

    // AND-OR select of the granted channel's data (grant is one-hot or zero).
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            mux_data = mux_data | (bus.in_data[i*BIT_SIZE +: BIT_SIZE] & {BIT_SIZE{grant[i]}});
        end
    end

    // Next state of the output stage and arbitration pointer; flush wins over load.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        rr_ptr_d    = rr_ptr_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (load) begin
            if (|grant) begin
                out_valid_d = 1'b1;
                out_data_d  = mux_data;
                out_sel_d   = grant_idx;
                if (MODE == MUX_MODE_RR) begin
                    // Explicit wrap keeps the pointer in range when NUM_IN is not a power of 2.
                    rr_ptr_d = (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + SEL_W'(1);
                end
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Output stage and pointer registers; reset discards any held word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed + random bench for rr_stream_mux: four instances (select/round-robin, 4 and 3
// channels) checked against a behavioural model feeding per-instance expectation queues.
module tb_rr_stream_mux;
    import rr_stream_mux_pkg::*;

    localparam int B = 18;

    typedef struct packed {
        logic [3:0]   sel;
        logic [B-1:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] sel4 = '0;
    logic [1:0] sel3 = '0;
    logic [1:0] sel_nc = '0;

    always #5 clk = ~clk;

    rr_stream_mux_if #(.NUM_IN(4), .BIT_SIZE(B)) bs ();
    rr_stream_mux_if #(.NUM_IN(4), .BIT_SIZE(B)) br ();
    rr_stream_mux_if #(.NUM_IN(3), .BIT_SIZE(B)) b3 ();
    rr_stream_mux_if #(.NUM_IN(3), .BIT_SIZE(B)) bs3 ();

    rr_stream_mux #(.BIT_SIZE(B), .NUM_IN(4), .MODE(MUX_MODE_SEL)) u_s4 (
        .clk(clk), .rst(rst), .flush_i(flush), .sel_i(sel4), .bus(bs));
    rr_stream_mux #(.BIT_SIZE(B), .NUM_IN(4), .MODE(MUX_MODE_RR)) u_r4 (
        .clk(clk), .rst(rst), .flush_i(flush), .sel_i(sel_nc), .bus(br));
    rr_stream_mux #(.BIT_SIZE(B), .NUM_IN(3), .MODE(MUX_MODE_RR)) u_r3 (
        .clk(clk), .rst(rst), .flush_i(flush), .sel_i(sel_nc), .bus(b3));
    rr_stream_mux #(.BIT_SIZE(B), .NUM_IN(3), .MODE(MUX_MODE_SEL)) u_s3 (
        .clk(clk), .rst(rst), .flush_i(flush), .sel_i(sel3), .bus(bs3));

    int   passed = 0;
    int   total  = 0;
    int   fails  = 0;
    exp_t q    [4][$];
    exp_t last [4];
    bit   mv   [4];
    bit   ldd  [4];
    int   ptr  [4];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int rr_pick(logic [3:0] v, int p, int n);
        for (int k = 0; k < n; k++) begin
            if (v[(p + k) % n]) return (p + k) % n;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 1'b0; ldd[i] = 1'b0; ptr[i] = 0; last[i] = '0;
            q[i].delete();
        end
    endtask

    // Predict this cycle's ready vector and, on a transfer, queue the expected word.
    task automatic pred(int i, int n, int mode, logic [3:0] v, int s, logic [4*B-1:0] d,
                        logic ordy, output logic [3:0] er);
        bit load;
        int pick;
        load   = !mv[i] || ordy;
        pick   = -1;
        er     = '0;
        ldd[i] = 1'b0;
        if (mode == 0) begin
            if (s < n && v[s]) pick = s;
        end else begin
            pick = rr_pick(v, ptr[i], n);
        end
        if (flush) begin
            mv[i] = 1'b0;
        end else if (load) begin
            if (pick >= 0) begin
                er[pick] = 1'b1;
                q[i].push_back(exp_t'{sel: 4'(pick), data: d[pick*B +: B]});
                if (mode == 1) ptr[i] = (pick == n - 1) ? 0 : pick + 1;
                mv[i]  = 1'b1;
                ldd[i] = 1'b1;
            end else begin
                mv[i] = 1'b0;
            end
        end
    endtask

    task automatic post(int i, string nm, logic ov, logic [3:0] os, logic [B-1:0] od);
        if (ldd[i]) last[i] = q[i].pop_front();
        chk({nm, ".valid"}, 32'(ov), 32'(mv[i]));
        chk({nm, ".sel"},   32'(os), 32'(last[i].sel));
        chk({nm, ".data"},  32'(od), 32'(last[i].data));
    endtask

    // One clock cycle: inputs were driven just after the previous edge.
    task automatic cyc();
        logic [3:0] er;
        #1;
        pred(0, 4, 0, bs.in_valid, int'(sel4), bs.in_data, bs.out_ready, er);
        chk("s4.ready", 32'(bs.in_ready), 32'(er));
        pred(1, 4, 1, br.in_valid, 0, br.in_data, br.out_ready, er);
        chk("r4.ready", 32'(br.in_ready), 32'(er));
        pred(2, 3, 1, {1'b0, b3.in_valid}, 0, {{B{1'b0}}, b3.in_data}, b3.out_ready, er);
        chk("r3.ready", 32'(b3.in_ready), 32'(er));
        pred(3, 3, 0, {1'b0, bs3.in_valid}, int'(sel3), {{B{1'b0}}, bs3.in_data}, bs3.out_ready, er);
        chk("s3.ready", 32'(bs3.in_ready), 32'(er));
        @(posedge clk);
        #1;
        post(0, "s4", bs.out_valid,  4'(bs.out_sel),  bs.out_data);
        post(1, "r4", br.out_valid,  4'(br.out_sel),  br.out_data);
        post(2, "r3", b3.out_valid,  4'(b3.out_sel),  b3.out_data);
        post(3, "s3", bs3.out_valid, 4'(bs3.out_sel), bs3.out_data);
        chk("r4.ptr", 32'(u_r4.rr_ptr_q), 32'(ptr[1]));
        chk("r3.ptr", 32'(u_r3.rr_ptr_q), 32'(ptr[2]));
    endtask

    task automatic check_reset(string tag);
        chk({tag, ".r4.valid"}, 32'(br.out_valid), 32'd0);
        chk({tag, ".r4.data"},  32'(br.out_data),  32'd0);
        chk({tag, ".r4.sel"},   32'(br.out_sel),   32'd0);
        chk({tag, ".r4.ready"}, 32'(br.in_ready),  32'd0);
        chk({tag, ".r4.ptr"},   32'(u_r4.rr_ptr_q), 32'd0);
        chk({tag, ".r3.ptr"},   32'(u_r3.rr_ptr_q), 32'd0);
        chk({tag, ".s4.valid"}, 32'(bs.out_valid), 32'd0);
        chk({tag, ".s4.data"},  32'(bs.out_data),  32'd0);
        chk({tag, ".s4.ready"}, 32'(bs.in_ready),  32'd0);
        chk({tag, ".r3.valid"}, 32'(b3.out_valid), 32'd0);
        chk({tag, ".s3.valid"}, 32'(bs3.out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        bs.in_data = '0;  bs.in_valid = '0;  bs.out_ready = 1'b0;
        br.in_data = '0;  br.in_valid = '0;  br.out_ready = 1'b0;
        b3.in_data = '0;  b3.in_valid = '0;  b3.out_ready = 1'b0;
        bs3.in_data = '0; bs3.in_valid = '0; bs3.out_ready = 1'b0;
        model_reset();

        // Reset: requests present but ready must stay low.
        br.in_valid = 4'hF; bs.in_valid = 4'hF; br.out_ready = 1'b1; bs.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset("rst");
        rst = 1'b0;
        br.in_valid = '0; bs.in_valid = '0;

        // External select, single valid channel.
        sel4 = 2'd2; bs.in_valid = 4'b0100; bs.out_ready = 1'b1;
        bs.in_data = 72'({$urandom(), $urandom(), $urandom()});
        bs.in_data[2*B +: B] = 18'h2A5A5;
        cyc();
        chk("s1.data", 32'(bs.out_data), 32'h2A5A5);
        chk("s1.sel",  32'(bs.out_sel),  32'd2);
        bs.in_valid = '0;
        cyc();

        // Select changes while stalled have no effect until load returns.
        bs.out_ready = 1'b0; bs.in_valid = 4'hF; sel4 = 2'd1;
        cyc();
        sel4 = 2'd3; cyc();
        sel4 = 2'd0; cyc();
        chk("s4.hold.sel", 32'(bs.out_sel), 32'd1);
        bs.out_ready = 1'b1;
        cyc();
        chk("s4.resume.sel", 32'(bs.out_sel), 32'd0);

        // Round robin, all channels valid: 0,1,2,3,0,1,2,3.
        br.in_valid = 4'hF; br.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            br.in_data = 72'({$urandom(), $urandom(), $urandom()});
            cyc();
            chk("s2.seq", 32'(br.out_sel), 32'(k % 4));
        end

        // Back-pressure for 3 cycles, then the next channel loads on release.
        br.out_ready = 1'b0;
        repeat (3) begin
            br.in_data = 72'({$urandom(), $urandom(), $urandom()});
            cyc();
        end
        chk("s3.hold.sel", 32'(br.out_sel), 32'd3);
        br.out_ready = 1'b1;
        cyc();
        chk("s3.next.sel", 32'(br.out_sel), 32'd0);

        // Three channels: wrap after channel 2; out-of-range select grants nothing.
        b3.out_ready = 1'b1; b3.in_valid = 3'b100;
        b3.in_data = 54'({$urandom(), $urandom()});
        cyc();
        chk("s4.r3.sel2", 32'(b3.out_sel), 32'd2);
        chk("s4.r3.ptr0", 32'(u_r3.rr_ptr_q), 32'd0);
        b3.in_valid = 3'b111;
        cyc();
        chk("s4.r3.wrap", 32'(b3.out_sel), 32'd0);
        sel3 = 2'd3; bs3.in_valid = 3'b111; bs3.out_ready = 1'b1;
        bs3.in_data = 54'({$urandom(), $urandom()});
        cyc();
        chk("s4.s3.nogrant", 32'(bs3.out_valid), 32'd0);
        sel3 = 2'd1;
        cyc();

        // Flush with everything valid and ready.
        br.in_valid = 4'hF; br.out_ready = 1'b1; flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("s5.valid", 32'(br.out_valid), 32'd0);

        // Random traffic on all four instances.
        for (int n = 0; n < 80; n++) begin
            bs.in_valid  = 4'($urandom());  br.in_valid  = 4'($urandom());
            b3.in_valid  = 3'($urandom());  bs3.in_valid = 3'($urandom());
            bs.out_ready = ($urandom_range(3) != 0); br.out_ready  = ($urandom_range(3) != 0);
            b3.out_ready = ($urandom_range(3) != 0); bs3.out_ready = ($urandom_range(3) != 0);
            sel4 = 2'($urandom()); sel3 = 2'($urandom());
            flush = ($urandom_range(7) == 0);
            bs.in_data  = 72'({$urandom(), $urandom(), $urandom()});
            br.in_data  = 72'({$urandom(), $urandom(), $urandom()});
            b3.in_data  = 54'({$urandom(), $urandom()});
            bs3.in_data = 54'({$urandom(), $urandom()});
            cyc();
        end
        flush = 1'b0;

        // Asynchronous reset between edges while streaming.
        br.in_valid = 4'hF; br.out_ready = 1'b1; bs.in_valid = 4'hF; bs.out_ready = 1'b1;
        sel4 = 2'd3;
        cyc();
        cyc();
        #3;
        rst = 1'b1;
        #1;
        check_reset("arst");
        model_reset();
        @(posedge clk);
        #1;
        check_reset("arst.hold");
        rst = 1'b0;
        cyc();
        chk("s6.restart", 32'(br.out_sel), 32'd0);
        cyc();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
